// File: rtl/div4b_seq.sv
// div4b_seq: sequential 4-bit unsigned restoring divider (Q = A / B, R = A mod B).
// Uses one addsub4b in subtract mode as its only arithmetic unit. It has a
// start/done handshake, and B = 0 is flagged through div_zero.

// addsub4b: 4-bit adder/subtractor. add_sub=1 computes A - B as A + ~B + 1.
// In subtract mode, Co=1 means no borrow (A >= B).
module addsub4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       add_sub,
    output logic [3:0] S,
    output logic       Co
);
    logic [3:0] b_eff;

    assign b_eff   = B ^ {4{add_sub}};
    assign {Co, S} = {1'b0, A} + {1'b0, b_eff} + {4'b0000, add_sub};
endmodule

module div4b_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ad_q, ad_d;
    logic [3:0] bd_q, bd_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic [1:0] cnt_q, cnt_d;
    logic       dz_q, dz_d;

    logic [3:0] p;
    logic [3:0] diff;
    logic       no_borrow;

    // Partial remainder shifted left, with the next dividend bit brought in.
    // R < Bd always holds, so R[3] is 0 and nothing is lost by the shift.
    assign p = {r_q[2:0], ad_q[cnt_q]};

    addsub4b u_sub (
        .A       (p),
        .B       (bd_q),
        .add_sub (1'b1),
        .S       (diff),
        .Co      (no_borrow)
    );

    // Next-state and datapath update for the accept / iterate / done sequence
    always_comb begin
        state_d = state_q;
        ad_d    = ad_q;
        bd_d    = bd_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    ad_d = A;
                    bd_d = B;
                    q_d  = '0;
                    r_d  = '0;
                    dz_d = 1'b0;
                    if (B == 4'd0) begin
                        // Divide by zero: the result goes in directly and no iteration runs.
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ITER;
                        cnt_d   = 2'd3;
                    end
                end
            end
            ITER: begin
                if (no_borrow) begin
                    r_d        = diff;
                    q_d[cnt_q] = 1'b1;
                end else begin
                    r_d        = p;
                    q_d[cnt_q] = 1'b0;
                end
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and counter registers with async clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ad_q    <= '0;
            bd_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ad_q    <= ad_d;
            bd_q    <= bd_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == ITER);
    assign done     = (state_q == DONE);
    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_div4b_seq.sv
// Testbench for div4b_seq. Expected results come from plain integer / and %.
module tb_div4b_seq;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [3:0] Q, R;
    logic       busy, done, div_zero;

    int checks   = 0;
    int failures = 0;

    // Last expected result; used to check that outputs hold while idle
    int exp_q = 0, exp_r = 0, exp_dz = 0;

    div4b_seq dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #50 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_expected(input int a, input int b);
        if (b == 0) begin
            exp_q = 15; exp_r = a; exp_dz = 1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dz = 0;
        end
    endtask

    // Issue one division at the current falling edge. Returns at the falling
    // edge where done is high, so a following call runs back-to-back.
    task automatic run(input int a, input int b, input bit poke);
        int unsigned n;
        A = 4'(a);
        B = 4'(b);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        A = 4'($urandom);
        B = 4'($urandom);
        n = 0;
        while (!done && n < 8) begin
            check("busy_during_iter", int'(busy), 1);
            start = (poke && n == 1) ? 1'b1 : 1'b0;
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        set_expected(a, b);
        check("latency", int'(n), (b == 0) ? 0 : 4);
        check("done", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
        check("Q", int'(Q), exp_q);
        check("R", int'(R), exp_r);
        check("div_zero", int'(div_zero), exp_dz);
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        check("idle_done", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("hold_Q", int'(Q), exp_q);
        check("hold_R", int'(R), exp_r);
        check("hold_dz", int'(div_zero), exp_dz);
    endtask

    initial begin
        int pulses;
        int got_q, got_r;

        // Reset state
        #1;
        check("rst_Q", int'(Q), 0);
        check("rst_R", int'(R), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dz", int'(div_zero), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Basic division, then back-to-back runs
        run(13, 3, 1'b0);
        idle_cycle();
        run(15, 1, 1'b0);
        run(2, 9, 1'b0);
        run(15, 15, 1'b0);
        idle_cycle();

        // Divide by zero, then a normal division that clears the flag
        run(7, 0, 1'b0);
        run(6, 2, 1'b0);
        idle_cycle();

        // Operands change and start is pulsed while busy; both are ignored
        A = 4'd9; B = 4'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        A = 4'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pulses = 0; got_q = -1; got_r = -1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                if (pulses == 0) begin
                    got_q = int'(Q);
                    got_r = int'(R);
                end
                pulses++;
            end
            @(negedge clock);
        end
        check("ignore_start_pulses", pulses, 1);
        check("ignore_start_Q", got_q, 4);
        check("ignore_start_R", got_r, 1);
        set_expected(9, 2);

        // Async reset in the middle of ITER discards the partial result
        A = 4'd14; B = 4'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #10 reset = 1'b1;
        #1;
        check("midrst_Q", int'(Q), 0);
        check("midrst_R", int'(R), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_dz", int'(div_zero), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run(14, 3, 1'b0);
        idle_cycle();

        // Exhaustive sweep, all back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run(a, b, 1'b0);
            end
        end
        idle_cycle();

        // Randomized operations with random gaps and ignored start pulses
        for (int k = 0; k < 60; k++) begin
            int gap;
            run(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                bit'($urandom_range(1, 0)));
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time limit so the bench cannot hang
    initial begin
        #20ms;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
